// File: rtl/overlay_fetch_sched_pkg.sv
// Shared state encoding, parameter defaults and address helper for the overlay
// counter-table fetch scheduler.
package overlay_fetch_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DATA,
    NEXT,
    CLEAR
  } fetchState_t;

  localparam int          DEF_TABLE_MAX = 20;
  localparam logic [23:0] DEF_BASE_A    = 24'h000000;
  localparam logic [23:0] DEF_BASE_B    = 24'h000100;
  localparam int          DEF_TIMEOUT   = 255;

  // Substituted for the table value when RAM never answers.
  localparam logic [15:0] TIMEOUT_DATA  = 16'h0FFF;
  localparam int          TIMER_W       = 16;

  function automatic logic [23:0] entryAddr(input logic [23:0] base,
                                            input logic [7:0]  index);
    return base + {16'd0, index};
  endfunction

endpackage

// File: rtl/overlay_fetch_sched_wait_timer.sv
// Read-data watchdog: cleared at grant, counts WAIT_DATA cycles and expires on
// the LIMIT-th one.
module overlay_wait_timer
  import overlay_fetch_sched_pkg::*;
#(
  parameter int LIMIT = DEF_TIMEOUT
) (
  input  logic CLOCK_50,
  input  logic RST_N,
  input  logic load_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(LIMIT - 1);

  logic [TIMER_W-1:0] count_q, count_d;

  // Saturates on the expiry value so a stalled read keeps signalling expiry.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/overlay_fetch_sched.sv
// Per-frame fetch of the source-A/B counter tables from shared RAM into the
// text overlay, interleaved A0,B0,A1,B1,... with timeout and clear handling.
module overlay_fetch_sched
  import overlay_fetch_sched_pkg::*;
#(
  parameter int          TABLE_MAX = DEF_TABLE_MAX,
  parameter logic [23:0] BASE_A    = DEF_BASE_A,
  parameter logic [23:0] BASE_B    = DEF_BASE_B,
  parameter int          TIMEOUT   = DEF_TIMEOUT
) (
  input  logic        CLOCK_50,
  input  logic        RST_N,
  input  logic        frame_start,
  input  logic        clear_req,
  output logic        mem_req,
  output logic [23:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata,
  output logic [23:0] ramAddress,
  output logic [15:0] ramData,
  output logic        flagReadOK,
  output logic [23:0] ramAddress02,
  output logic [15:0] ramData02,
  output logic        flagReadOK02,
  output logic        resetMode,
  output logic        busy,
  output logic        overrun,
  output logic        timeout_err
);

  localparam logic [7:0] LAST_INDEX = 8'(TABLE_MAX - 1);

  fetchState_t state_q, state_d;
  logic [7:0]  index_q, index_d;
  logic        srcB_q, srcB_d;
  logic        strobeA_q, strobeA_d, strobeB_q, strobeB_d;
  logic [7:0]  addrA_q, addrA_d, addrB_q, addrB_d;
  logic [15:0] dataA_q, dataA_d, dataB_q, dataB_d;
  logic        overrun_q, overrun_d;
  logic        timeoutErr_q, timeoutErr_d;
  logic        clrPend_q, clrPend_d;

  logic        timerLoad, timerEnable, timerExpire;
  logic        abortNow;
  logic [15:0] readData;

  overlay_wait_timer #(
    .LIMIT (TIMEOUT)
  ) u_waitTimer (
    .CLOCK_50 (CLOCK_50),
    .RST_N    (RST_N),
    .load_i   (timerLoad),
    .enable_i (timerEnable),
    .expire_o (timerExpire)
  );

  // A pending clear suppresses the request so no new read is started.
  assign mem_req     = (state_q == ISSUE) && !clrPend_q;
  assign mem_addr    = mem_req ? entryAddr(srcB_q ? BASE_B : BASE_A, index_q) : 24'd0;
  assign timerLoad   = mem_req && mem_gnt;
  assign timerEnable = (state_q == WAIT_DATA);
  assign abortNow    = clear_req || clrPend_q;
  assign readData    = mem_rvalid ? mem_rdata : TIMEOUT_DATA;

  assign busy         = (state_q != IDLE);
  assign resetMode    = (state_q == CLEAR);
  assign overrun      = overrun_q;
  assign timeout_err  = timeoutErr_q;
  assign flagReadOK   = strobeA_q;
  assign flagReadOK02 = strobeB_q;
  assign ramAddress   = {16'd0, addrA_q};
  assign ramAddress02 = {16'd0, addrB_q};
  assign ramData      = dataA_q;
  assign ramData02    = dataB_q;

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    srcB_d       = srcB_q;
    strobeA_d    = 1'b0;
    strobeB_d    = 1'b0;
    addrA_d      = addrA_q;
    addrB_d      = addrB_q;
    dataA_d      = dataA_q;
    dataB_d      = dataB_q;
    overrun_d    = overrun_q || (frame_start && busy);
    timeoutErr_d = timeoutErr_q;
    clrPend_d    = clrPend_q || (clear_req && busy && (state_q != CLEAR));

    unique case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
        end else if (frame_start) begin
          state_d = ISSUE;
          index_d = 8'd0;
          srcB_d  = 1'b0;
        end
      end

      ISSUE: begin
        if (clrPend_q) begin
          state_d = CLEAR;
        end else if (mem_gnt) begin
          state_d = WAIT_DATA;
        end
      end

      // An aborted read still runs to completion, but its data is dropped.
      WAIT_DATA: begin
        if (mem_rvalid || timerExpire) begin
          if (!mem_rvalid) begin
            timeoutErr_d = 1'b1;
          end
          if (abortNow) begin
            state_d = CLEAR;
          end else begin
            state_d = NEXT;
            if (srcB_q) begin
              strobeB_d = 1'b1;
              addrB_d   = index_q;
              dataB_d   = readData;
            end else begin
              strobeA_d = 1'b1;
              addrA_d   = index_q;
              dataA_d   = readData;
            end
          end
        end
      end

      NEXT: begin
        if (clrPend_q) begin
          state_d = CLEAR;
        end else begin
          srcB_d  = !srcB_q;
          state_d = ISSUE;
          if (srcB_q) begin
            if (index_q == LAST_INDEX) begin
              state_d = IDLE;
              index_d = 8'd0;
            end else begin
              index_d = index_q + 8'd1;
            end
          end
        end
      end

      CLEAR: begin
        state_d = IDLE;
        index_d = 8'd0;
        srcB_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == CLEAR) begin
      overrun_d    = 1'b0;
      timeoutErr_d = 1'b0;
      clrPend_d    = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      index_q      <= 8'd0;
      srcB_q       <= 1'b0;
      strobeA_q    <= 1'b0;
      strobeB_q    <= 1'b0;
      addrA_q      <= 8'd0;
      addrB_q      <= 8'd0;
      dataA_q      <= 16'd0;
      dataB_q      <= 16'd0;
      overrun_q    <= 1'b0;
      timeoutErr_q <= 1'b0;
      clrPend_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      srcB_q       <= srcB_d;
      strobeA_q    <= strobeA_d;
      strobeB_q    <= strobeB_d;
      addrA_q      <= addrA_d;
      addrB_q      <= addrB_d;
      dataA_q      <= dataA_d;
      dataB_q      <= dataB_d;
      overrun_q    <= overrun_d;
      timeoutErr_q <= timeoutErr_d;
      clrPend_q    <= clrPend_d;
    end
  end

endmodule

// File: tb/tb_overlay_fetch_sched.sv
// Bench for overlay_fetch_sched: a randomized RAM responder feeds the DUT and
// every overlay write is checked against a queue of expected table writes.
module tb_overlay_fetch_sched;

  localparam int          TM   = 20;
  localparam logic [23:0] BA   = 24'h000000;
  localparam logic [23:0] BB   = 24'h000100;
  localparam int          TO   = 255;
  localparam logic [23:0] NONE = 24'hFFFFFF;

  typedef struct {
    logic        isB;
    logic [23:0] index;
    logic [15:0] data;
    logic        timedOut;
  } expWrite_t;

  logic        CLOCK_50 = 1'b0;
  logic        RST_N = 1'b0;
  logic        frame_start = 1'b0;
  logic        clear_req = 1'b0;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [15:0] mem_rdata = 16'd0;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic [23:0] ramAddress, ramAddress02;
  logic [15:0] ramData, ramData02;
  logic        flagReadOK, flagReadOK02;
  logic        resetMode, busy, overrun, timeout_err;

  expWrite_t   expQ[$];
  int          compared = 0;
  int          mismatched = 0;
  int          resetPulses = 0;

  logic        detMode = 1'b1;
  logic [23:0] stallAddr = NONE;
  logic [23:0] dropAddr = NONE;
  logic [23:0] slowAddr = NONE;
  int          slowLat = 2;

  overlay_fetch_sched #(
    .TABLE_MAX (TM),
    .BASE_A    (BA),
    .BASE_B    (BB),
    .TIMEOUT   (TO)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .RST_N        (RST_N),
    .frame_start  (frame_start),
    .clear_req    (clear_req),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .ramAddress   (ramAddress),
    .ramData      (ramData),
    .flagReadOK   (flagReadOK),
    .ramAddress02 (ramAddress02),
    .ramData02    (ramData02),
    .flagReadOK02 (flagReadOK02),
    .resetMode    (resetMode),
    .busy         (busy),
    .overrun      (overrun),
    .timeout_err  (timeout_err)
  );

  initial forever #10 CLOCK_50 = ~CLOCK_50;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic fs, input logic cr);
    frame_start = fs;
    clear_req   = cr;
    @(negedge CLOCK_50);
    frame_start = 1'b0;
    clear_req   = 1'b0;
  endtask

  // Expected overlay writes: the first numWrites entries of A0,B0,A1,B1,...
  task automatic planFrame(input int numWrites, input int timeoutBIndex);
    expWrite_t   e;
    logic [23:0] a;
    for (int i = 0; i < TM; i++) begin
      for (int s = 0; s < 2; s++) begin
        if (2 * i + s < numWrites) begin
          a          = (s == 1 ? BB : BA) + 24'(i);
          e.isB      = (s == 1);
          e.index    = 24'(i);
          e.timedOut = (s == 1) && (i == timeoutBIndex);
          e.data     = e.timedOut ? 16'h0FFF : 16'h0100 + a[15:0];
          expQ.push_back(e);
        end
      end
    end
  endtask

  task automatic checkWrite(input logic isB, input logic [23:0] addr, input logic [15:0] data);
    expWrite_t e;
    checkOutput("writeExpected", 32'(expQ.size() > 0), 32'd1);
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("writePort", 32'(isB), 32'(e.isB));
      checkOutput("writeAddr", 32'(addr), 32'(e.index));
      checkOutput("writeData", 32'(data), 32'(e.data));
      if (e.timedOut) checkOutput("timeoutFlag", 32'(timeout_err), 32'd1);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_req"}, 32'(mem_req), 32'd0);
    checkOutput({tag, "_addr"}, 32'(mem_addr), 32'd0);
    checkOutput({tag, "_strobes"}, 32'({flagReadOK, flagReadOK02, resetMode}), 32'd0);
    checkOutput({tag, "_ramA"}, 32'({ramAddress[15:0], ramData}), 32'd0);
    checkOutput({tag, "_ramB"}, 32'({ramAddress02[15:0], ramData02}), 32'd0);
    checkOutput({tag, "_ramHi"}, 32'({ramAddress[23:16], ramAddress02[23:16]}), 32'd0);
    checkOutput({tag, "_flags"}, 32'({busy, overrun, timeout_err}), 32'd0);
  endtask

  task automatic waitIdle(input int limit, output int cycles);
    cycles = 0;
    while (busy && cycles < limit) begin
      @(negedge CLOCK_50);
      cycles++;
    end
    checkOutput("idleReached", 32'(busy), 32'd0);
  endtask

  task automatic waitReq(input logic [23:0] target, input int limit, output logic found);
    found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      if (mem_req && mem_addr == target) found = 1'b1;
      else @(negedge CLOCK_50);
    end
  endtask

  task automatic waitGrantTaken(input string tag);
    int n;
    n = 0;
    while (mem_req && n < 10) begin
      @(negedge CLOCK_50);
      n++;
    end
    checkOutput(tag, 32'(mem_req), 32'd0);
  endtask

  // RAM model: grant after a stall, data = 16'h0100 + address after a latency.
  initial begin : memResponder
    logic [23:0] a;
    int          stall;
    int          lat;
    forever begin
      @(negedge CLOCK_50);
      if (mem_req) begin
        a     = mem_addr;
        stall = (a == stallAddr) ? 50 : (detMode ? 0 : int'($urandom_range(0, 3)));
        lat   = (a == slowAddr) ? slowLat : (detMode ? 2 : int'($urandom_range(1, 4)));
        for (int k = 0; k < stall; k++) begin
          if (a == stallAddr) begin
            checkOutput("stallReq", 32'(mem_req), 32'd1);
            checkOutput("stallAddr", 32'(mem_addr), 32'(a));
          end
          @(negedge CLOCK_50);
        end
        mem_gnt = 1'b1;
        @(negedge CLOCK_50);
        mem_gnt = 1'b0;
        if (a != dropAddr) begin
          repeat (lat - 1) @(negedge CLOCK_50);
          mem_rvalid = 1'b1;
          mem_rdata  = 16'h0100 + a[15:0];
          @(negedge CLOCK_50);
          mem_rvalid = 1'b0;
        end
      end
    end
  end

  initial begin : writeMonitor
    forever begin
      @(negedge CLOCK_50);
      if (resetMode) begin
        resetPulses++;
        checkOutput("clearNoWrite", 32'({flagReadOK, flagReadOK02}), 32'd0);
      end
      if (flagReadOK)   checkWrite(1'b0, ramAddress, ramData);
      if (flagReadOK02) checkWrite(1'b1, ramAddress02, ramData02);
    end
  end

  initial begin : watchdog
    repeat (90000) @(posedge CLOCK_50);
    $display("[TB] FAIL watchdog: observed run still active expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int   cycles;
    int   pulsesBefore;
    logic found;
    logic sawReq;

    repeat (3) @(negedge CLOCK_50);
    checkAllZero("reset");
    RST_N = 1'b1;
    @(negedge CLOCK_50);
    checkOutput("idleBusy", 32'(busy), 32'd0);

    $display("[TB] frame 1: fixed grant/latency");
    detMode = 1'b1;
    planFrame(2 * TM, -1);
    applyStimulus(1'b1, 1'b0);
    waitIdle(1000, cycles);
    checkOutput("frame1Fast", 32'(cycles + 1 < 2 * TM * (4 + 2)), 32'd1);
    checkOutput("frame1Left", 32'(expQ.size()), 32'd0);
    checkOutput("frame1Flags", 32'({overrun, timeout_err}), 32'd0);

    $display("[TB] frame 2: random timing, stall A3, drop B7, restart at B10");
    detMode   = 1'b0;
    stallAddr = BA + 24'd3;
    dropAddr  = BB + 24'd7;
    planFrame(2 * TM, 7);
    applyStimulus(1'b1, 1'b0);
    waitReq(BB + 24'd10, 3000, found);
    checkOutput("reachB10", 32'(found), 32'd1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("overrunSet", 32'(overrun), 32'd1);
    waitIdle(3000, cycles);
    checkOutput("frame2Left", 32'(expQ.size()), 32'd0);
    checkOutput("frame2Timeout", 32'(timeout_err), 32'd1);
    checkOutput("frame2Overrun", 32'(overrun), 32'd1);
    repeat (5) @(negedge CLOCK_50);
    checkOutput("noRestart", 32'({busy, mem_req}), 32'd0);
    stallAddr = NONE;
    dropAddr  = NONE;

    $display("[TB] frame 3: clear during A12 read");
    slowAddr = BA + 24'd12;
    slowLat  = 6;
    planFrame(24, -1);
    pulsesBefore = resetPulses;
    applyStimulus(1'b1, 1'b0);
    waitReq(BA + 24'd12, 1000, found);
    checkOutput("reachA12", 32'(found), 32'd1);
    waitGrantTaken("a12Granted");
    applyStimulus(1'b0, 1'b1);
    repeat (15) @(negedge CLOCK_50);
    checkOutput("clearPulses", 32'(resetPulses - pulsesBefore), 32'd1);
    checkOutput("clearFlags", 32'({overrun, timeout_err, busy}), 32'd0);
    checkOutput("clearLeft", 32'(expQ.size()), 32'd0);
    slowAddr = NONE;

    $display("[TB] simultaneous frame_start and clear_req in IDLE");
    pulsesBefore = resetPulses;
    sawReq = 1'b0;
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      if (mem_req) sawReq = 1'b1;
      @(negedge CLOCK_50);
    end
    checkOutput("simulNoFetch", 32'(sawReq), 32'd0);
    checkOutput("simulPulses", 32'(resetPulses - pulsesBefore), 32'd1);
    checkOutput("simulBusy", 32'(busy), 32'd0);

    $display("[TB] reset during A2 read");
    detMode  = 1'b1;
    slowAddr = BA + 24'd2;
    slowLat  = 8;
    planFrame(4, -1);
    applyStimulus(1'b1, 1'b0);
    waitReq(BA + 24'd2, 200, found);
    checkOutput("reachA2", 32'(found), 32'd1);
    waitGrantTaken("a2Granted");
    RST_N = 1'b0;
    #1;
    checkAllZero("midRst");
    repeat (2) @(negedge CLOCK_50);
    RST_N = 1'b1;
    repeat (15) @(negedge CLOCK_50);
    checkAllZero("postRst");
    checkOutput("rstLeft", 32'(expQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/overlay_fetch_sched.md
OVERLAY_FETCH_SCHED -- requirements
Module: overlay_fetch_sched

Interface
REQ-001 Parameter TABLE_MAX, default 20, number of counter-table entries fetched per source per frame (1..255).
REQ-002 Parameter BASE_A, default 24'h000000, RAM word address of source-A table entry 0.
REQ-003 Parameter BASE_B, default 24'h000100, RAM word address of source-B table entry 0.
REQ-004 Parameter TIMEOUT, default 255, maximum cycles to wait for read data.
REQ-005 CLOCK_50  in  1  system clock; all logic SHALL be on its rising edge.
REQ-006 RST_N  in  1  reset, asynchronous, active-low.
REQ-007 frame_start  in  1  one-cycle pulse at start of vertical blank.
REQ-008 clear_req  in  1  one-cycle request to zero the overlay table.
REQ-009 mem_req  out  1  read request to shared RAM port, held until granted.
REQ-010 mem_addr  out  24  read word address, stable while mem_req=1.
REQ-011 mem_gnt  in  1  RAM port accepts request this cycle.
REQ-012 mem_rvalid  in  1  read data valid, one cycle, after grant.
REQ-013 mem_rdata  in  16  read data.
REQ-014 ramAddress / ramData / flagReadOK  out  24 / 16 / 1  source-A table write to the text overlay.
REQ-015 ramAddress02 / ramData02 / flagReadOK02  out  24 / 16 / 1  source-B table write to the text overlay.
REQ-016 resetMode  out  1  table-clear command to the text overlay.
REQ-017 busy  out  1  high whenever FSM is not IDLE.
REQ-018 overrun  out  1  sticky flag: frame_start arrived while busy.
REQ-019 timeout_err  out  1  sticky flag: a read exceeded TIMEOUT cycles.

Function
REQ-020 FSM states SHALL be IDLE, ISSUE, WAIT_DATA, NEXT, CLEAR.
REQ-021 IDLE: frame_start -> ISSUE with index=0, src=A; clear_req -> CLEAR; clear_req SHALL win if both arrive in the same cycle.
REQ-022 ISSUE: mem_req=1, mem_addr=(src?BASE_B:BASE_A)+index (24-bit, wrap modulo 2^24); mem_gnt -> WAIT_DATA with timer cleared, mem_req dropping the next cycle.
REQ-023 WAIT_DATA: mem_rvalid -> write strobe for the current src one cycle later, then NEXT; timer reaching TIMEOUT -> set timeout_err, write strobe with data 16'h0FFF, then NEXT.
REQ-024 Write strobe: flagReadOK (src A) or flagReadOK02 (src B) high exactly one cycle; matching ramAddress*={16'd0,index[7:0]}, ramData* = captured mem_rdata, held until the next strobe on that port.
REQ-025 Order SHALL be interleaved A0,B0,A1,B1,...; NEXT toggles src, increments index after B; after B(TABLE_MAX-1) -> IDLE.
REQ-026 A mem_rvalid outside WAIT_DATA SHALL be ignored.
REQ-027 frame_start while busy: ignored, overrun set; the fetch in progress completes unchanged.
REQ-028 clear_req while busy: abort at the next cycle not in WAIT_DATA (a pending read completes and is discarded), then CLEAR.
REQ-029 CLEAR: resetMode high exactly one cycle, no strobes that cycle, then IDLE.
REQ-030 Sticky flags SHALL be cleared only by reset or by a clear_req accepted into CLEAR.
REQ-031 Latency: grant-to-strobe SHALL be (cycles to mem_rvalid)+1; total frame fetch without stalls SHALL be under 2*TABLE_MAX*(4+read latency) cycles.

Reset
REQ-032 On RST_N low, all outputs SHALL be 0 immediately, FSM IDLE, index 0, src A, timer 0.
REQ-033 Reset mid-fetch SHALL abandon the transaction; after release no strobe for it SHALL appear.

Structure
REQ-034 State encoding and defaults for TABLE_MAX, BASE_A, BASE_B, TIMEOUT SHALL live in the shared overlay package.
REQ-035 One sub-module, overlay_wait_timer (load/enable/expire counter), SHALL implement the WAIT_DATA timeout.

Verification
REQ-036 frame_start with 1-cycle grant and rvalid 2 cycles after grant, mem data = 16'h0100+addr: 40 strobes in order A0,B0,...; A5 carries ramData=16'h0105 with ramAddress=5.
REQ-037 Hold mem_gnt low 50 cycles during A3: mem_req and mem_addr=BASE_A+3 stable throughout; no strobe until the grant.
REQ-038 Withhold mem_rvalid for B7: timeout_err=1 after 255 cycles, flagReadOK02 with ramData02=16'h0FFF, ramAddress02=7, fetch continues with A8.
REQ-039 frame_start at entry B10: overrun=1, sequence finishes at B19, no restart.
REQ-040 clear_req at A12 in WAIT_DATA: the A12 read is discarded, resetMode pulses once, flags clear, busy=0; simultaneous frame_start+clear_req in IDLE yields only CLEAR.
REQ-041 RST_N asserted mid-WAIT_DATA then rvalid arrives: no strobe; all outputs 0.
